// File: rtl/apb4_slave_mem_pkg.sv
// Shared definitions for the APB4 slave memory: default widths, FSM states
// and the byte-lane helper used to size PSTRB.
package apb4_package;

  localparam int DEFAULT_ADDR_WIDTH  = 8;
  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_WAIT_CYCLES = 0;
  localparam int DEFAULT_ERR_WIDTH   = 8;
  localparam int WAIT_CTR_WIDTH      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic int strb_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb4_wait_ctr.sv
// Wait-state counter: loaded at the start of a transfer, counts down to zero
// while the slave stretches the ACCESS phase.
module apb4_wait_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 slave backed by a flip-flop memory with configurable wait states,
// byte strobes, address error reporting and a saturating error counter.
module apb4_slave_mem
  import apb4_package::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int ERR_WIDTH   = DEFAULT_ERR_WIDTH
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [ERR_WIDTH-1:0]    err_count
);

  localparam int LANES      = strb_lanes(DATA_WIDTH);
  localparam int LANE_SHIFT = $clog2(LANES);
  localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e            state;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [LANES-1:0]      cap_strb;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wait_zero;
  logic [ADDR_WIDTH-1:0] word_index;
  logic [IDX_WIDTH-1:0]  mem_index;
  logic                  xfer_err;
  logic                  xfer_done;

  apb4_wait_ctr #(
    .WIDTH(WAIT_CTR_WIDTH)
  ) u_wait_ctr (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .load       (state == SETUP),
    .load_value (WAIT_CTR_WIDTH'(WAIT_CYCLES)),
    .dec        (state == ACCESS),
    .zero       (wait_zero)
  );

  // Decode works only on the captured transfer so outputs never see live bus inputs.
  assign word_index = cap_addr >> LANE_SHIFT;
  assign mem_index  = word_index[IDX_WIDTH-1:0];
  assign xfer_err   = ({1'b0, word_index} >= (ADDR_WIDTH+1)'(DEPTH)) ||
                      ((cap_addr & ADDR_WIDTH'(LANES - 1)) != '0);
  assign xfer_done  = (state == ACCESS) && wait_zero;

  assign PREADY  = xfer_done;
  assign PSLVERR = xfer_done && xfer_err;
  assign PRDATA  = (xfer_done && !cap_write && !xfer_err) ? mem[mem_index] : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) state <= SETUP;
        end
        SETUP: begin
          cap_addr  <= PADDR;
          cap_write <= PWRITE;
          cap_wdata <= PWDATA;
          cap_strb  <= PSTRB;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (wait_zero) begin
            if (xfer_err && err_count != '1) err_count <= err_count + ERR_WIDTH'(1);
            state <= (PSEL && !PENABLE) ? SETUP : IDLE;
          end else if (!(PSEL && PENABLE)) begin
            // Master abandoned the transfer: drop it silently.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (xfer_done && cap_write && !xfer_err) begin
      for (int b = 0; b < LANES; b++) begin
        if (cap_strb[b]) mem[mem_index][8*b +: 8] <= cap_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/apb4_slave_mem.md
APB4_SLAVE_MEM -- requirements
Module: apb4_slave_mem

Interface
REQ-001 Parameter ADDR_WIDTH, 8, PADDR width in bits (byte address).
REQ-002 Parameter DATA_WIDTH, 32, PWDATA/PRDATA width; legal values are 8, 16 and 32.
REQ-003 Parameter DEPTH, 16, number of DATA_WIDTH-bit words; DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH.
REQ-004 Parameter WAIT_CYCLES, 0, number of PREADY-low ACCESS cycles per transfer (0..15).
REQ-005 Parameter ERR_WIDTH, 8, width of the error counter.
REQ-006 PCLK input 1: single clock; all state updates on its rising edge.
REQ-007 PRESETn input 1: reset, asynchronous assert, active-low.
REQ-008 PSEL input 1: slave select.
REQ-009 PENABLE input 1: ACCESS-phase indicator.
REQ-010 PWRITE input 1: 1 = write, 0 = read.
REQ-011 PADDR input ADDR_WIDTH: byte address.
REQ-012 PWDATA input DATA_WIDTH: write data.
REQ-013 PSTRB input DATA_WIDTH/8: write byte enables.
REQ-014 PRDATA output DATA_WIDTH: read data.
REQ-015 PREADY output 1: transfer completion.
REQ-016 PSLVERR output 1: transfer error, qualified by PREADY.
REQ-017 err_count output ERR_WIDTH: saturating count of errored transfers.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP and ACCESS: IDLE->SETUP on PSEL&!PENABLE; SETUP->ACCESS unconditionally; in ACCESS with PREADY=1, ->SETUP if PSEL&!PENABLE, else ->IDLE.
REQ-019 On the SETUP cycle, PADDR, PWRITE, PWDATA and PSTRB SHALL be captured and the wait counter loaded with WAIT_CYCLES.
REQ-020 In ACCESS, the counter SHALL decrement each cycle while nonzero; PREADY SHALL be 1 only when state is ACCESS and the counter is 0 (WAIT_CYCLES=0 gives a zero-wait transfer).
REQ-021 PREADY, PSLVERR and PRDATA SHALL be driven from registered state only, with no combinational path from the APB inputs.
REQ-022 The word index SHALL be the captured PADDR >> log2(DATA_WIDTH/8).
REQ-023 The transfer is in error if index >= DEPTH or the captured address is not word-aligned.
REQ-024 On an error, PSLVERR SHALL be 1 during the PREADY=1 cycle, no memory update SHALL occur, PRDATA SHALL be 0, and err_count SHALL increment, saturating at all-ones.
REQ-025 A valid write SHALL update only the bytes whose PSTRB bit is 1, on the PREADY=1 cycle; PSTRB=0 is a legal no-op write.
REQ-026 A valid read SHALL present mem[index] on PRDATA in the PREADY=1 cycle; PRDATA SHALL be 0 in all other cycles and for writes.
REQ-027 PSTRB SHALL be ignored on reads.
REQ-028 If PSEL or PENABLE drops while in ACCESS before PREADY (protocol violation), the FSM SHALL go to IDLE with no memory update and no err_count change.
REQ-029 Back-to-back transfers SHALL need no idle cycle; a read following a write to the same index SHALL return the new data.

Reset
REQ-030 PRESETn low SHALL immediately force state IDLE, counter 0, PREADY 0, PSLVERR 0, PRDATA 0, err_count 0, and all memory words 0.
REQ-031 A reset during ACCESS SHALL abort the transfer with no partial write.
REQ-032 The first transfer after PRESETn deasserts SHALL begin with a normal SETUP cycle.

Structure
REQ-033 Package apb4_package SHALL hold the default widths, the FSM state enum (IDLE, SETUP, ACCESS) and the function computing byte-enable lane count from DATA_WIDTH.
REQ-034 Sub-module apb4_wait_ctr (load, decrement, zero flag) SHALL implement the wait counter.
REQ-035 The memory SHALL be a flip-flop array inside apb4_slave_mem.

Verification (DATA_WIDTH=32, DEPTH=16, WAIT_CYCLES=2, ERR_WIDTH=8 unless stated)
REQ-036 Write 0xDEADBEEF to 0x08 with PSTRB=0xF, then read 0x08 -> PREADY high on the 3rd ACCESS cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-037 Write 0x11223344 to 0x04 with PSTRB=0xF, then 0xAABBCCDD with PSTRB=0x5, then read 0x04 -> 0x11BB33DD.
REQ-038 Write to 0x40 (index 16) and read 0x02 (misaligned) -> PSLVERR=1 with PREADY on both, PRDATA=0, memory unchanged, err_count=2.
REQ-039 Issue 300 errored transfers -> err_count saturates at 0xFF.
REQ-040 With WAIT_CYCLES=0, run back-to-back write/read to 0x0C -> each transfer completes in 2 cycles and the read returns the written value.
REQ-041 Assert PRESETn low during the 2nd ACCESS cycle of a write to 0x00 -> outputs are 0 at once and a later read of 0x00 returns 0.
